// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter, one transaction in flight (IDLE -> ACCESS -> RESP).
// Define DMEM_ARB_RR_EN for round-robin grant; otherwise req0 has fixed priority with a req1 starvation guard.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_rvalid,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_rvalid,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_id, r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_gnt1, w_idle, w_access, w_resp, w_accept, w_misal;
`ifdef DMEM_ARB_RR_EN
  // r_ptr names the requester favoured on the next simultaneous request
  logic r_ptr;
  assign w_gnt1 = req1_valid && (!req0_valid || r_ptr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= 1'b0;
    else if (w_accept) r_ptr <= !w_gnt1;
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve;
  assign w_gnt1 = req1_valid && (!req0_valid || r_starve >= CW'(STARVE_LIMIT));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_starve <= '0;
    else if (w_accept) r_starve <= (w_gnt1 || !req1_valid) ? '0 : r_starve + 1'b1;
`endif
  assign w_idle     = rst_n && (r_state == IDLE);
  assign w_access   = r_state == ACCESS;
  assign w_resp     = r_state == RESP;
  assign req0_ready = w_idle && req0_valid && !w_gnt1;
  assign req1_ready = w_idle && w_gnt1;
  assign w_accept   = req0_ready || req1_ready;
  assign w_misal    = |r_addr[1:0];
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = ACCESS;
    else if (w_access) w_next = RESP;
    else if (w_resp) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_id    <= w_gnt1;
      r_we    <= w_gnt1 ? req1_we    : req0_we;
      r_addr  <= w_gnt1 ? req1_addr  : req0_addr;
      r_wdata <= w_gnt1 ? req1_wdata : req0_wdata;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rdata <= '0;
    else if (w_access) r_rdata <= mem_read ? mem_rdata : '0;
  assign mem_read    = w_access && !r_we && !w_misal;
  assign mem_write   = w_access && r_we && !w_misal;
  assign mem_addr    = w_access ? r_addr : '0;
  assign mem_wdata   = w_access ? r_wdata : '0;
  assign req0_rvalid = w_resp && !r_id;
  assign req1_rvalid = w_resp && r_id;
  assign req0_rdata  = req0_rvalid ? r_rdata : '0;
  assign req1_rdata  = req1_rvalid ? r_rdata : '0;
  assign req0_err    = req0_rvalid && w_misal;
  assign req1_err    = req1_rvalid && w_misal;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a word-addressed memory model.
module tb_dmem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_ready, req0_we = 1'b0, req0_rvalid, req0_err;
  logic [31:0] req0_addr = '0, req0_wdata = '0, req0_rdata;
  logic        req1_valid = 1'b0, req1_ready, req1_we = 1'b0, req1_rvalid, req1_err;
  logic [31:0] req1_addr = '0, req1_wdata = '0, req1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:63];
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int n, input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask
  function automatic logic rdy(input int n);
    return n == 0 ? req0_ready : req1_ready;
  endfunction
  function automatic logic [37:0] all_out;
    return {req0_ready, req1_ready, req0_rvalid, req1_rvalid, req0_err, req1_err,
            mem_read, mem_write, mem_addr | mem_wdata | req0_rdata | req1_rdata};
  endfunction
  task automatic wait_ready(input int n);
    int k = 0;
    while (!rdy(n) && k < 8) begin
      tick;
      k++;
    end
    chk("ready", {31'd0, rdy(n)}, 32'd1);
  endtask
  task automatic xact(input int n, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_err);
    logic ok;
    ok = a[1:0] == 2'b00;
    set_req(n, 1'b1, we, a, d);
    #1;
    wait_ready(n);
    tick;
    set_req(n, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("acc_read", {31'd0, mem_read}, {31'd0, !we && ok});
    chk("acc_write", {31'd0, mem_write}, {31'd0, we && ok});
    chk("acc_addr", mem_addr, a);
    chk("acc_wdata", mem_wdata, d);
    chk("acc_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    tick;
    chk("rvalid", {30'd0, req1_rvalid, req0_rvalid}, n == 0 ? 32'd1 : 32'd2);
    chk("rdata", n == 0 ? req0_rdata : req1_rdata, exp_d);
    chk("err", {31'd0, n == 0 ? req0_err : req1_err}, {31'd0, exp_err});
    chk("resp_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    tick;
    chk("rvalid_end", {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
  endtask
  initial begin
    logic [9:0] exp_g;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    tick;
    chk("rst_out", 32'(all_out()), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    tick;
    chk("idle_out", 32'(all_out()), 32'd0);
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    xact(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    xact(1, 1'b1, 32'h14, 32'hCAFEF00D, 32'd0, 1'b0);
    xact(1, 1'b0, 32'h14, 32'd0, 32'hCAFEF00D, 1'b0);
    xact(0, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
    xact(1, 1'b1, 32'h12, 32'h55, 32'd0, 1'b1);
    xact(1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
    #1;
    wait_ready(1);
    tick;
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_pre_write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", 32'(all_out()), 32'd0);
    chk("rst_async_hi", {26'd0, all_out() >> 32}, 32'd0);
    tick;
    chk("rst_hold_out", 32'(all_out()), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    chk("rst_no_rvalid", {30'd0, req1_rvalid, req0_rvalid}, 32'd0);
    xact(1, 1'b0, 32'h20, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    tick;
    @(negedge clk) rst_n = 1'b1;
    tick;
`ifdef DMEM_ARB_RR_EN
    exp_g = 10'h2AA;
`else
    exp_g = 10'h210;
`endif
    set_req(0, 1'b1, 1'b0, 32'h10, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'h14, 32'd0);
    #1;
    for (int i = 0; i < 10; i++) begin
      int k = 0;
      while (!(req0_ready || req1_ready) && k < 8) begin
        tick;
        k++;
      end
      chk($sformatf("both_ready_%0d", i), {31'd0, req0_ready && req1_ready}, 32'd0);
      chk($sformatf("grant_%0d", i), {30'd0, req1_ready, req0_ready}, exp_g[i] ? 32'd2 : 32'd1);
      tick;
      tick;
      tick;
    end
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    chk("final_idle", 32'(all_out()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
